// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler: samples an async 4-bit ripple counter into a wrap-extended count with valid/ready output; define SKIP_DETECT_EN for sticky Skip_err
module ripple_count_sampler #(
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [3:0]        Q_in,
  input  logic              Clear,
  input  logic              Out_ready,
  output logic [WRAP_W+3:0] Ext_count,
  output logic              Out_valid,
  output logic              Wrap,
  output logic              Skip_err
);
  typedef enum logic {INIT, TRACK} state_t;
  state_t state, state_d;
  logic [3:0] s1, s2, s3, l;
  logic [WRAP_W-1:0] high, high_nx;
  logic stable, absorb, accept, wrap_inf;
  // sample qualification, wrap inference and next state
  always_comb begin
    stable = s2 == s3;
    absorb = state == INIT && stable;
    accept = state == TRACK && stable && s2 != l;
    wrap_inf = s2 < l;
    high_nx = high + WRAP_W'(wrap_inf);
    state_d = Clear ? INIT : absorb ? TRACK : state;
  end
  // two-flop synchronizer plus a third stage to detect a settled code
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= Q_in;
      s2 <= s1;
      s3 <= s2;
    end
  // state register
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= INIT;
    else state <= state_d;
  // last accepted low value, wrap count, output register and handshake
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      l <= '0;
      high <= '0;
      Ext_count <= '0;
      Out_valid <= 1'b0;
      Wrap <= 1'b0;
    end else if (Clear) begin
      high <= '0;
      Out_valid <= 1'b0;
      Wrap <= 1'b0;
    end else begin
      Wrap <= accept && wrap_inf;
      if (absorb || accept) l <= s2;
      if (accept) begin
        high <= high_nx;
        Ext_count <= {high_nx, s2};
        Out_valid <= 1'b1;
      end else if (Out_ready) Out_valid <= 1'b0;
    end
`ifdef SKIP_DETECT_EN
  logic [3:0] delta;
  assign delta = s2 - l;
  // sticky flag for any accepted step other than +1
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) Skip_err <= 1'b0;
    else if (Clear) Skip_err <= 1'b0;
    else if (accept && delta != 4'd1) Skip_err <= 1'b1;
`else
  assign Skip_err = 1'b0;
`endif
endmodule

// File: doc/ripple_count_sampler.md
RIPPLE_COUNT_SAMPLER -- requirements
Module: ripple_count_sampler

Interface
REQ-001 The block SHALL have parameter WRAP_W, default 8: width of the wrap-extension (high) field of the extended count.
REQ-002 Port Clk, input, 1 bit: the single system clock; all state SHALL change on the rising edge only.
REQ-003 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port Q_in, input, 4 bits: output of the upstream 4-bit asynchronous ripple up counter, which is asynchronous to Clk and may glitch.
REQ-005 Port Clear, input, 1 bit: synchronous clear.
REQ-006 Port Out_ready, input, 1 bit: the consumer accepts Ext_count.
REQ-007 Port Ext_count, output, WRAP_W+4 bits: {high, low}; low is the last accepted Q_in value and high is the wrap count.
REQ-008 Port Out_valid, output, 1 bit: Ext_count holds a value the consumer has not yet taken.
REQ-009 Port Wrap, output, 1 bit: one-cycle pulse when high increments.
REQ-010 Port Skip_err, output, 1 bit: sticky error flag (see Configuration).

Function
REQ-011 Q_in SHALL pass through a two-flop synchronizer (s1, s2), followed by a third register s3.
REQ-012 A sample SHALL be stable when s2 == s3.
REQ-013 A sample SHALL be accepted when it is stable and s2 != L, where L is the last accepted low value.
REQ-014 Latency: for a Q_in value held constant, the acceptance and the Ext_count update SHALL occur on the 4th rising Clk edge after Q_in settles.
REQ-015 State machine INIT: the first stable sample SHALL load L (even if equal to 0), SHALL NOT set Out_valid, and SHALL move the machine to TRACK.
REQ-016 State machine TRACK: each accepted sample SHALL update L and Ext_count.low.
REQ-017 In TRACK, if the accepted value s2 < L (wrap inferred), high SHALL increment modulo 2^WRAP_W and Wrap SHALL pulse for exactly one cycle.
REQ-018 In TRACK, a delta of s2 - L (mod 16) not equal to 1 SHALL be a skip; a skip SHALL still be accepted, and REQ-017 still applies.
REQ-019 Acceptance SHALL set Out_valid=1 and load Ext_count in the same edge.
REQ-020 Out_valid SHALL clear on the edge where Out_valid && Out_ready, unless an acceptance occurs on that same edge, in which case the new value loads and Out_valid stays 1.
REQ-021 An acceptance while Out_valid=1 and Out_ready=0 SHALL overwrite Ext_count with the newest value; Out_valid stays 1.
REQ-022 Ext_count SHALL be stable whenever Out_valid=1 and no acceptance occurs.
REQ-023 High wrap-around: high=2^WRAP_W-1 plus a wrap SHALL give high=0, and Wrap SHALL pulse.
REQ-024 Clear=1 SHALL, on the next edge, set high=0, Out_valid=0, Wrap=0, Skip_err=0, and state=INIT; the synchronizer is unaffected.
REQ-025 Clear SHALL take priority over any acceptance on the same edge.

Reset
REQ-026 Reset=0 SHALL immediately force s1, s2, s3, L, and Ext_count to 0, Out_valid=0, Wrap=0, Skip_err=0, and state=INIT, independent of Clk.
REQ-027 Reset asserted mid-operation (including with Out_valid=1) SHALL discard the pending value; no handshake completes.
REQ-028 After Reset deasserts, operation SHALL resume at INIT on the next rising edge.

Configuration
REQ-029 With macro SKIP_DETECT_EN defined, Skip_err SHALL set on any skip in TRACK and hold until Reset or Clear.
REQ-030 Without SKIP_DETECT_EN, Skip_err SHALL be constant 0 and no skip logic SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-031 Scenario 1: Reset low 30 ns, then Q_in steps 0,1,2 every 40 ns, Out_ready=1 -> INIT absorbs 0; Ext_count=0x001, then 0x002; each Out_valid high for 1 cycle.
REQ-032 Scenario 2: Q_in 14,15,0,1 -> Ext_count 0x00E, 0x00F, 0x010 with a Wrap pulse coincident, then 0x011.
REQ-033 Scenario 3: Q_in glitches 7->6->4->8 with each code held 1 cycle, settling at 8 from L=7 -> 8 is the only acceptance; Ext_count.low=8; Skip_err=0.
REQ-034 Scenario 4: with SKIP_DETECT_EN, Q_in jumps 3->9 -> Ext_count.low=9 and Skip_err=1 sticky until Clear; without the macro, Skip_err=0.
REQ-035 Scenario 5: Out_ready=0 while Q_in advances 1,2,3 -> Out_valid stays 1 and Ext_count=0x003; raising Out_ready for 1 cycle clears Out_valid.
REQ-036 Scenario 6: high=0xFF with a wrap 15->0 -> Ext_count=0x000 and Wrap pulses; Reset pulse with Out_valid=1 -> all outputs 0 immediately.
